// File: rtl/microseq_pkg.sv
// Shared definitions for the microsequencer.
// Holds the opcode encodings, the opcode width, the default reset and trap
// vectors, and the per-cycle control bundle that the opcode decoder
// produces and the trap/hold arbitration then gates.
package microseq_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_CONT = 4'd0;
   localparam logic [OP_W-1:0] OP_JMP  = 4'd1;
   localparam logic [OP_W-1:0] OP_CJMP = 4'd2;
   localparam logic [OP_W-1:0] OP_JSR  = 4'd3;
   localparam logic [OP_W-1:0] OP_CJSR = 4'd4;
   localparam logic [OP_W-1:0] OP_RET  = 4'd5;
   localparam logic [OP_W-1:0] OP_CRET = 4'd6;
   localparam logic [OP_W-1:0] OP_LDCT = 4'd7;
   localparam logic [OP_W-1:0] OP_LOOP = 4'd8;
   localparam logic [OP_W-1:0] OP_PUSH = 4'd9;
   localparam logic [OP_W-1:0] OP_MAP  = 4'd10;
   localparam logic [OP_W-1:0] OP_CASE = 4'd11;
   localparam logic [OP_W-1:0] OP_LDAR = 4'd12;
   localparam logic [OP_W-1:0] OP_JAR  = 4'd13;

   localparam int          DEF_ADDR_W       = 11;
   localparam logic [10:0] DEF_RESET_VECTOR = 11'h000;
   localparam logic [10:0] DEF_TRAP_VECTOR  = 11'h7F0;

   // Side effects requested by one cycle of sequencing.
   typedef struct packed {
      logic push;
      logic pop;
      logic ld_ctr;
      logic dec_ctr;
      logic ld_ar;
   } seq_ctrl_t;

endpackage

// File: rtl/micro_stack.sv
// Subroutine return-address LIFO for the microsequencer.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   push_i, pop_i    stack operations (push takes precedence if both set)
//   data_i           value written on push
//   clr_err_i        clears the sticky error flags (a same-cycle set wins)
//   top_o            stack[sp-1], or stack[0] when empty
//   full_o, empty_o  sp == STACK_DEPTH / sp == 0
//   ovf_o, unf_o     sticky: push while full / pop while empty
// A push while full is discarded and a pop while empty leaves sp at 0.
module micro_stack #(
   parameter int ADDR_W      = 11,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] data_i,
   input  logic              clr_err_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              ovf_o,
   output logic              unf_o
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  top_idx;

   assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
   assign empty_o = (sp_q == '0);
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

   // sp never reaches STACK_DEPTH while writing, so the truncated index is safe.
   assign wr_idx  = IDX_W'(sp_q);
   assign top_idx = empty_o ? '0 : IDX_W'(sp_q - SP_W'(1));
   assign top_o   = mem_q[top_idx];

   // NOTE: every variable gets a default before any branch, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q & ~clr_err_i;
      unf_d = unf_q & ~clr_err_i;
      wr_en = 1'b0;
      if (push_i) begin
         if (full_o) begin
            ovf_d = 1'b1;
         end else begin
            wr_en = 1'b1;
            sp_d  = sp_q + SP_W'(1);
         end
      end else if (pop_i) begin
         if (empty_o) begin
            unf_d = 1'b1;
         end else begin
            sp_d = sp_q - SP_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // NOTE: the entries are reset because an underflowing pop returns
   // stack[0], which must read as zero after reset rather than as X.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/microsequencer.sv
// Microcode address sequencer (successor to the Am2909/Am2911 slices).
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   op, d, cc, cc_pol   opcode, direct value and condition from the pipeline reg
//   case_bits, map_in   case OR-in bits and map ROM dispatch address
//   hold, trap_req      stall (freezes everything) and trap request
//   clr_err             clears the sticky stack error flags
//   uc_address          combinational next microcode address (Y)
//   trap_ack            high in the cycle a trap is taken
//   stack_empty/full    stack occupancy
//   stack_ovf/unf       sticky stack error flags
//   counter_zero        loop counter is zero
// Priority: hold > trap > opcode.
module microsequencer
   import microseq_pkg::*;
#(
   parameter int                ADDR_W       = DEF_ADDR_W,
   parameter int                STACK_DEPTH  = 4,
   parameter int                COUNTER_W    = 8,
   parameter int                CASE_W       = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
   parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(DEF_TRAP_VECTOR)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [OP_W-1:0]   op,
   input  logic [ADDR_W-1:0] d,
   input  logic              cc,
   input  logic              cc_pol,
   input  logic [CASE_W-1:0] case_bits,
   input  logic [ADDR_W-1:0] map_in,
   input  logic              hold,
   input  logic              trap_req,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] uc_address,
   output logic              trap_ack,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              stack_ovf,
   output logic              stack_unf,
   output logic              counter_zero
);

   logic [ADDR_W-1:0]    upc_q, upc_d;
   logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0]    ar_q, ar_d;
   logic [COUNTER_W-1:0] counter_q, counter_d;

   logic                 pass;
   logic [ADDR_W-1:0]    top;
   logic [ADDR_W-1:0]    op_y;
   logic [ADDR_W-1:0]    y;
   logic [ADDR_W-1:0]    push_data;
   seq_ctrl_t            op_ctrl;
   seq_ctrl_t            ctrl;
   logic                 take_trap;

   assign pass         = cc ^ cc_pol;
   assign counter_zero = (counter_q == '0);

   // Opcode decode: address the opcode would issue and its side effects.
   always_comb begin
      op_y    = upc_q;
      op_ctrl = '0;
      case (op)
         OP_JMP:  op_y = d;
         OP_CJMP: if (pass) op_y = d;
         OP_JSR: begin
            op_y         = d;
            op_ctrl.push = 1'b1;
         end
         OP_CJSR: if (pass) begin
            op_y         = d;
            op_ctrl.push = 1'b1;
         end
         OP_RET: begin
            op_y        = top;
            op_ctrl.pop = 1'b1;
         end
         OP_CRET: if (pass) begin
            op_y        = top;
            op_ctrl.pop = 1'b1;
         end
         OP_LDCT: op_ctrl.ld_ctr = 1'b1;
         OP_LOOP: begin
            // Re-enter the body at the pushed address until the counter
            // runs out, then fall through and discard the loop address.
            if (!counter_zero) begin
               op_y            = top;
               op_ctrl.dec_ctr = 1'b1;
            end else begin
               op_ctrl.pop = 1'b1;
            end
         end
         OP_PUSH: op_ctrl.push = 1'b1;
         OP_MAP:  op_y = map_in;
         OP_CASE: op_y = d | ADDR_W'(case_bits);
         OP_LDAR: op_ctrl.ld_ar = 1'b1;
         OP_JAR:  op_y = ar_q;
         default: ;
      endcase
   end

   // Hold/trap arbitration on top of the decoded opcode.
   always_comb begin
      y         = op_y;
      ctrl      = op_ctrl;
      push_data = upc_q;
      take_trap = 1'b0;
      if (hold) begin
         y    = cur_addr_q;
         ctrl = '0;
      end else if (trap_req) begin
         // The address the opcode would have issued becomes the return point.
         y         = TRAP_VECTOR;
         ctrl      = '0;
         ctrl.push = 1'b1;
         push_data = op_y;
         take_trap = 1'b1;
      end
   end

   assign uc_address = reset_n ? y : RESET_VECTOR;
   assign trap_ack   = reset_n & take_trap;

   always_comb begin
      upc_d      = upc_q;
      cur_addr_d = cur_addr_q;
      ar_d       = ar_q;
      counter_d  = counter_q;
      if (!hold) begin
         upc_d      = y + ADDR_W'(1);
         cur_addr_d = y;
         if (ctrl.ld_ar)   ar_d      = d;
         if (ctrl.ld_ctr)  counter_d = d[COUNTER_W-1:0];
         if (ctrl.dec_ctr) counter_d = counter_q - COUNTER_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         upc_q      <= RESET_VECTOR;
         cur_addr_q <= RESET_VECTOR;
         ar_q       <= '0;
         counter_q  <= '0;
      end else begin
         upc_q      <= upc_d;
         cur_addr_q <= cur_addr_d;
         ar_q       <= ar_d;
         counter_q  <= counter_d;
      end
   end

   micro_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clock     (clock),
      .reset_n   (reset_n),
      .push_i    (ctrl.push),
      .pop_i     (ctrl.pop),
      .data_i    (push_data),
      .clr_err_i (clr_err & ~hold),
      .top_o     (top),
      .full_o    (stack_full),
      .empty_o   (stack_empty),
      .ovf_o     (stack_ovf),
      .unf_o     (stack_unf)
   );

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer with hand-computed
// expected addresses and flags.
module tb_microsequencer;
   import microseq_pkg::*;

   logic        clock;
   logic        reset_n;
   logic [3:0]  op;
   logic [10:0] d;
   logic        cc;
   logic        cc_pol;
   logic [3:0]  case_bits;
   logic [10:0] map_in;
   logic        hold;
   logic        trap_req;
   logic        clr_err;
   logic [10:0] uc_address;
   logic        trap_ack;
   logic        stack_empty;
   logic        stack_full;
   logic        stack_ovf;
   logic        stack_unf;
   logic        counter_zero;

   int checks = 0;
   int errors = 0;

   microsequencer #(
      .ADDR_W       (11),
      .STACK_DEPTH  (4),
      .COUNTER_W    (8),
      .CASE_W       (4),
      .RESET_VECTOR (11'h000),
      .TRAP_VECTOR  (11'h7F0)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .op           (op),
      .d            (d),
      .cc           (cc),
      .cc_pol       (cc_pol),
      .case_bits    (case_bits),
      .map_in       (map_in),
      .hold         (hold),
      .trap_req     (trap_req),
      .clr_err      (clr_err),
      .uc_address   (uc_address),
      .trap_ack     (trap_ack),
      .stack_empty  (stack_empty),
      .stack_full   (stack_full),
      .stack_ovf    (stack_ovf),
      .stack_unf    (stack_unf),
      .counter_zero (counter_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Apply one opcode, check the combinational address, then clock it in.
   task automatic step(input logic [3:0] o, input logic [10:0] dv,
                       input logic [10:0] ey, input string tag);
      op = o;
      d  = dv;
      #1;
      check(tag, uc_address, ey);
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      op        = OP_CONT;
      d         = '0;
      cc        = 1'b0;
      cc_pol    = 1'b0;
      case_bits = '0;
      map_in    = '0;
      hold      = 1'b0;
      trap_req  = 1'b0;
      clr_err   = 1'b0;

      // Reset state; the opcode and trap inputs must be ignored while low.
      #12;
      check("rst_y", uc_address, 11'h000);
      check("rst_empty", stack_empty, 1'b1);
      check("rst_full", stack_full, 1'b0);
      check("rst_ovf", stack_ovf, 1'b0);
      check("rst_unf", stack_unf, 1'b0);
      check("rst_czero", counter_zero, 1'b1);
      op = OP_JMP; d = 11'h555; trap_req = 1'b1;
      #1;
      check("rst_y_jmp", uc_address, 11'h000);
      check("rst_ack", trap_ack, 1'b0);
      op = OP_CONT; d = '0; trap_req = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // 1: sequential fetch from the reset vector
      step(OP_CONT, 11'h000, 11'h000, "t1_y0");
      step(OP_CONT, 11'h000, 11'h001, "t1_y1");
      step(OP_CONT, 11'h000, 11'h002, "t1_y2");
      step(OP_CONT, 11'h000, 11'h003, "t1_y3");
      step(OP_CONT, 11'h000, 11'h004, "t1_y4");
      check("t1_empty", stack_empty, 1'b1);

      // 2: subroutine call from the instruction at 0x010
      step(OP_JMP,  11'h010, 11'h010, "t2_jmp");
      step(OP_JSR,  11'h123, 11'h123, "t2_jsr");
      check("t2_not_empty", stack_empty, 1'b0);
      step(OP_CONT, 11'h000, 11'h124, "t2_c1");
      step(OP_CONT, 11'h000, 11'h125, "t2_c2");
      step(OP_RET,  11'h000, 11'h011, "t2_ret");
      check("t2_empty", stack_empty, 1'b1);

      // 3: counted loop, body issued 4 times then fall through
      step(OP_LDCT, 11'h003, 11'h012, "t3_ldct");
      check("t3_cnz", counter_zero, 1'b0);
      step(OP_PUSH, 11'h000, 11'h013, "t3_push");
      step(OP_LOOP, 11'h000, 11'h013, "t3_loop1");
      step(OP_LOOP, 11'h000, 11'h013, "t3_loop2");
      step(OP_LOOP, 11'h000, 11'h013, "t3_loop3");
      step(OP_LOOP, 11'h000, 11'h014, "t3_fall");
      check("t3_cz", counter_zero, 1'b1);
      check("t3_empty", stack_empty, 1'b1);

      // 4: overflow on the fifth call, underflow on the fifth return
      step(OP_JSR, 11'h100, 11'h100, "t4_jsr1");
      step(OP_JSR, 11'h101, 11'h101, "t4_jsr2");
      step(OP_JSR, 11'h102, 11'h102, "t4_jsr3");
      step(OP_JSR, 11'h103, 11'h103, "t4_jsr4");
      check("t4_full4", stack_full, 1'b1);
      check("t4_no_ovf", stack_ovf, 1'b0);
      step(OP_JSR, 11'h104, 11'h104, "t4_jsr5");
      check("t4_ovf", stack_ovf, 1'b1);
      check("t4_full5", stack_full, 1'b1);
      step(OP_RET, 11'h000, 11'h103, "t4_ret1");
      check("t4_not_full", stack_full, 1'b0);
      step(OP_RET, 11'h000, 11'h102, "t4_ret2");
      step(OP_RET, 11'h000, 11'h101, "t4_ret3");
      step(OP_RET, 11'h000, 11'h015, "t4_ret4");
      check("t4_empty", stack_empty, 1'b1);
      check("t4_no_unf", stack_unf, 1'b0);
      step(OP_RET, 11'h000, 11'h015, "t4_ret5");
      check("t4_unf", stack_unf, 1'b1);
      check("t4_empty5", stack_empty, 1'b1);
      clr_err = 1'b1;
      step(OP_RET, 11'h000, 11'h015, "t4_ret6_clr");
      check("t4_set_wins", stack_unf, 1'b1);
      check("t4_ovf_clr", stack_ovf, 1'b0);
      step(OP_CONT, 11'h000, 11'h016, "t4_clr");
      check("t4_unf_clr", stack_unf, 1'b0);
      clr_err = 1'b0;

      // 5: case OR-in, map dispatch, conditional branches, AR, reserved op
      case_bits = 4'b0101;
      step(OP_CASE, 11'h200, 11'h205, "t5_case");
      case_bits = 4'b0000;
      map_in = 11'h3A0;
      step(OP_MAP, 11'h000, 11'h3A0, "t5_map");
      cc = 1'b0; cc_pol = 1'b1;
      step(OP_CJMP, 11'h0AB, 11'h0AB, "t5_cjmp_taken");
      cc = 1'b1; cc_pol = 1'b1;
      step(OP_CJMP, 11'h0CC, 11'h0AC, "t5_cjmp_not");
      step(OP_LDAR, 11'h2CD, 11'h0AD, "t5_ldar");
      step(OP_JAR,  11'h000, 11'h2CD, "t5_jar");
      step(4'd14,   11'h7FF, 11'h2CE, "t5_rsv14");
      cc = 1'b1; cc_pol = 1'b0;
      step(OP_CJSR, 11'h111, 11'h111, "t5_cjsr");
      cc = 1'b0;
      step(OP_CRET, 11'h000, 11'h112, "t5_cret_not");
      cc = 1'b1;
      step(OP_CRET, 11'h000, 11'h2CF, "t5_cret_taken");
      check("t5_empty", stack_empty, 1'b1);
      cc = 1'b0;

      // 6: trap vectoring, hold priority, trap suppresses counter load
      trap_req = 1'b1;
      op = OP_JMP; d = 11'h050;
      #1;
      check("t6_trap_y", uc_address, 11'h7F0);
      check("t6_trap_ack", trap_ack, 1'b1);
      tick();
      check("t6_trap_push", stack_empty, 1'b0);
      hold = 1'b1;
      op = OP_JMP; d = 11'h055;
      #1;
      check("t6_hold_y", uc_address, 11'h7F0);
      check("t6_hold_ack", trap_ack, 1'b0);
      tick();
      hold = 1'b0; trap_req = 1'b0;
      step(OP_RET, 11'h000, 11'h050, "t6_ret_top");
      check("t6_empty", stack_empty, 1'b1);
      trap_req = 1'b1;
      step(OP_LDCT, 11'h005, 11'h7F0, "t6_trap_ldct");
      trap_req = 1'b0;
      check("t6_no_ld", counter_zero, 1'b1);
      step(OP_RET, 11'h000, 11'h051, "t6_ret_ldct");

      // Reset in the middle of a subroutine discards the stack.
      step(OP_JSR, 11'h300, 11'h300, "t6_jsr");
      check("t6_in_sub", stack_empty, 1'b0);
      op = OP_CONT; d = '0;
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_y", uc_address, 11'h000);
      check("t6_rst_empty", stack_empty, 1'b1);
      tick();
      reset_n = 1'b1;
      step(OP_CONT, 11'h000, 11'h000, "t6_post_rst");
      step(OP_RET,  11'h000, 11'h000, "t6_ret_empty");
      check("t6_unf", stack_unf, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Parametrised successor to the cascaded Am2909/Am2911 slice sequencers that drive the microcode ROM address.
- Provides, in a single block of configurable width:
  - next-address selection
  - a subroutine stack of configurable depth with overflow/underflow detection
  - a loop counter
  - a holding register (AR)
  - case OR-in
  - map-ROM dispatch
  - trap vectoring
  - stall
- Sits between the pipeline register (op, d, cc fields) and the microcode ROM address input.

Parameters:
- ADDR_W, 11, microcode address width (uPC, AR, stack entries, d, map_in).
- STACK_DEPTH, 4, number of subroutine stack entries (>=2).
- COUNTER_W, 8, loop counter width; loaded from d[COUNTER_W-1:0], with COUNTER_W <= ADDR_W.
- CASE_W, 4, width of case_bits, OR-ed into d[CASE_W-1:0].
- RESET_VECTOR, 11'h000, address presented during and after reset.
- TRAP_VECTOR, 11'h7F0, address forced on an accepted trap.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  4  sequencer opcode from the pipeline register.
- d  in  ADDR_W  direct branch address / counter load / AR load value.
- cc  in  1  condition input.
- cc_pol  in  1  1 = branch when cc = 0.
- case_bits  in  CASE_W  case OR-in bits (e.g. ALU zero).
- map_in  in  ADDR_W  map ROM dispatch address.
- hold  in  1  stall; freeze all state.
- trap_req  in  1  trap request, sampled every cycle.
- clr_err  in  1  clears the sticky error flags.
- uc_address  out  ADDR_W  combinational next microcode address (Y).
- trap_ack  out  1  high in the cycle a trap is taken.
- stack_empty  out  1  sp == 0.
- stack_full  out  1  sp == STACK_DEPTH.
- stack_ovf  out  1  sticky; push attempted while full.
- stack_unf  out  1  sticky; pop attempted while empty.
- counter_zero  out  1  counter == 0.

Behaviour:
- State registers: upc, ar, counter, sp, stack[], cur_addr, ovf, unf.
- Y (uc_address) is combinational from state and inputs. At each posedge, unless hold: upc <= Y+1 (mod 2^ADDR_W) and cur_addr <= Y.
- Condition: pass = cc ^ cc_pol. Top of stack = stack[sp-1]; when empty, top reads stack[0].
- Opcodes:
  - 0 CONT: Y = upc.
  - 1 JMP: Y = d.
  - 2 CJMP: Y = pass ? d : upc.
  - 3 JSR: Y = d; push upc.
  - 4 CJSR: Y = pass ? d : upc; push upc only if pass.
  - 5 RET: Y = top; pop.
  - 6 CRET: Y = pass ? top : upc; pop only if pass.
  - 7 LDCT: Y = upc; counter <= d[COUNTER_W-1:0].
  - 8 LOOP: if counter != 0, Y = top and counter <= counter-1; else Y = upc and pop.
  - 9 PUSH: Y = upc; push upc.
  - 10 MAP: Y = map_in.
  - 11 CASE: Y = d | zero-extended case_bits.
  - 12 LDAR: Y = upc; ar <= d.
  - 13 JAR: Y = ar.
  - 14, 15: reserved, behave as CONT.
- Push while full: write discarded, sp unchanged, ovf <= 1.
- Pop while empty: sp stays 0, Y uses stack[0], unf <= 1.
- Trap (trap_req=1, hold=0):
  - Y = TRAP_VECTOR; the opcode's Y is pushed instead of being issued.
  - All other opcode side effects are suppressed: no counter/AR load, no opcode pop.
  - trap_ack = 1 combinationally.
  - Trap push while full follows the overflow rule above.
- Hold: Y = cur_addr; no register changes; trap_req is ignored and trap_ack = 0.
- hold has priority over trap, which has priority over op.
- clr_err = 1: ovf and unf clear next edge; a same-cycle set wins over the clear.
- Reset (async, reset_n=0):
  - upc = cur_addr = RESET_VECTOR; Y = RESET_VECTOR while low.
  - sp = 0, counter = 0, ar = 0, stack entries = 0.
  - ovf = unf = 0; trap_ack = 0.
  - Reset mid-subroutine discards the whole stack.
- First cycle after release executes op normally from upc = RESET_VECTOR.
- Address latency: 0 cycles to Y, 1 cycle to upc/stack update.

Decomposition:
- Shared package microseq_pkg holds:
  - opcode localparams (OP_CONT..OP_JAR)
  - op width 4
  - default vector constants
- One sub-module, micro_stack (STACK_DEPTH x ADDR_W LIFO): push, pop, top, sp, full/empty, with the saturating overflow/underflow rule. Loop/counter logic stays in the top module.

Test Plan:
1. Reset with op = CONT for 5 cycles -> Y = 0x000, 0x001, 0x002, 0x003, 0x004; stack_empty = 1.
2. JSR d = 0x123 at upc = 0x010, then CONT, CONT, RET -> Y = 0x123, 0x124, 0x125, 0x011; sp returns to 0.
3. LDCT d = 3, PUSH, then LOOP repeatedly at the same address -> the loop body repeats 4 times, then falls through; counter_zero = 1 and the stack is empty.
4. Five JSRs with STACK_DEPTH = 4 -> stack_ovf = 1 after the fifth, sp = 4. Then five RETs -> stack_unf = 1 on the fifth. clr_err clears both flags.
5. CASE d = 0x200, case_bits = 4'b0101 -> Y = 0x205. MAP with map_in = 0x3A0 -> Y = 0x3A0. CJMP with cc = 0, cc_pol = 1 -> branch taken.
6. trap_req during JMP d = 0x050 -> Y = 0x7F0, trap_ack = 1, stack top = 0x050. With hold = 1 asserted simultaneously -> Y = cur_addr, no trap taken. reset_n pulsed low mid-subroutine -> Y = 0x000 immediately, stack_empty = 1.
